// File: rtl/full_adder_pkg.sv
// Shared definitions for the dual-implementation full adder.
//   Y_W    : width of the {carry,sum} result
//   fa_ref : behavioural reference, returns a + b + c zero-extended to Y_W bits
package full_adder_pkg;

   localparam int Y_W = 2;

   function automatic logic [Y_W-1:0] fa_ref(input logic a, input logic b, input logic c);
      return {1'b0, a} + {1'b0, b} + {1'b0, c};
   endfunction

endpackage

// File: rtl/fa_gates.sv
// Gate-level 1-bit full adder built only from primitive gate instances.
// Ports:
//   sum   out  (a ^ b) ^ c
//   carry out  (a & b) | (c & (a ^ b))
//   a, b  in   addend bits
//   c     in   carry-in bit
module fa_gates (
   output logic sum,
   output logic carry,
   input  logic a,
   input  logic b,
   input  logic c
);

   logic ab_x;
   logic ab_a;
   logic cab_a;

   xor u_x0 (ab_x, a, b);
   xor u_x1 (sum, ab_x, c);
   and u_a0 (ab_a, a, b);
   and u_a1 (cab_a, c, ab_x);
   or  u_o0 (carry, ab_a, cab_a);

endmodule

// File: rtl/full_adder_dual.sv
// Self-checking full adder cell: the same sum is computed by a gate netlist
// and by a behavioural expression, both are registered, and the registered
// results are compared every valid cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       qualifies a, b, c
//   a, b, c        input bits
//   out_valid      registered in_valid
//   y_structural   registered {carry,sum} from fa_gates
//   y_other        registered {carry,sum} from fa_ref
//   mismatch       registered compare, 0 whenever out_valid is 0
//   err_sticky     set by any mismatch, cleared only by reset
//   vec_count      accepted vectors modulo 2^CNT_W
module full_adder_dual
   import full_adder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic             out_valid,
   output logic [Y_W-1:0]   y_structural,
   output logic [Y_W-1:0]   y_other,
   output logic             mismatch,
   output logic             err_sticky,
   output logic [CNT_W-1:0] vec_count
);

   logic             sum_s;
   logic             carry_s;
   logic [Y_W-1:0]   y_gate;
   logic [Y_W-1:0]   y_beh;

   logic             out_valid_d,  out_valid_q;
   logic [Y_W-1:0]   y_str_d,      y_str_q;
   logic [Y_W-1:0]   y_oth_d,      y_oth_q;
   logic             mismatch_d,   mismatch_q;
   logic             err_sticky_d, err_sticky_q;
   logic [CNT_W-1:0] vec_count_d,  vec_count_q;

   fa_gates u_gates (
      .sum   (sum_s),
      .carry (carry_s),
      .a     (a),
      .b     (b),
      .c     (c)
   );

   assign y_gate = {carry_s, sum_s};
   assign y_beh  = fa_ref(a, b, c);

   always_comb begin
      out_valid_d  = in_valid;
      y_str_d      = y_str_q;
      y_oth_d      = y_oth_q;
      mismatch_d   = 1'b0;
      vec_count_d  = vec_count_q;
      if (in_valid) begin
         y_str_d     = y_gate;
         y_oth_d     = y_beh;
         // Compare the values being captured so mismatch lines up with the y outputs.
         mismatch_d  = (y_gate != y_beh);
         vec_count_d = vec_count_q + 1'b1;
      end
      err_sticky_d = err_sticky_q | mismatch_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         y_str_q      <= '0;
         y_oth_q      <= '0;
         mismatch_q   <= 1'b0;
         err_sticky_q <= 1'b0;
         vec_count_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         y_str_q      <= y_str_d;
         y_oth_q      <= y_oth_d;
         mismatch_q   <= mismatch_d;
         err_sticky_q <= err_sticky_d;
         vec_count_q  <= vec_count_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign y_structural = y_str_q;
   assign y_other      = y_oth_q;
   assign mismatch     = mismatch_q;
   assign err_sticky   = err_sticky_q;
   assign vec_count    = vec_count_q;

endmodule

// File: tb/tb_full_adder_dual.sv
// Directed bench for full_adder_dual: a CNT_W=8 instance for function checks
// and a CNT_W=2 instance sharing the same stimulus for the counter wrap.
module tb_full_adder_dual;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       a, b, c;

   logic       out_valid,  out_valid2;
   logic [1:0] y_str,      y_str2;
   logic [1:0] y_oth,      y_oth2;
   logic       mismatch,   mismatch2;
   logic       err_sticky, err_sticky2;
   logic [7:0] vec_count;
   logic [1:0] vec_count2;

   int checks   = 0;
   int failures = 0;

   // Hand-written truth table, index {a,b,c}
   logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   always #5 clk = ~clk;

   full_adder_dual #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
      .out_valid(out_valid), .y_structural(y_str), .y_other(y_oth),
      .mismatch(mismatch), .err_sticky(err_sticky), .vec_count(vec_count)
   );

   full_adder_dual #(.CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .c(c),
      .out_valid(out_valid2), .y_structural(y_str2), .y_other(y_oth2),
      .mismatch(mismatch2), .err_sticky(err_sticky2), .vec_count(vec_count2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] abc);
      in_valid = v;
      {a, b, c} = abc;
   endtask

   task automatic do_reset();
      drive(1'b0, 3'b000);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(1'b0, 3'b000);
      rst_n = 1'b0;
      #2;
      checks += 6;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      if (y_str !== 2'b00) begin failures++; $display("FAIL reset_y_structural got=%b exp=00", y_str); end
      if (y_oth !== 2'b00) begin failures++; $display("FAIL reset_y_other got=%b exp=00", y_oth); end
      if (mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b exp=0", mismatch); end
      if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
      if (vec_count !== 8'd0) begin failures++; $display("FAIL reset_vec_count got=%0d exp=0", vec_count); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      for (int v = 0; v < 8; v++) begin
         drive(1'b1, 3'(v));
         step();
         checks += 4;
         if (y_str !== tt[v]) begin failures++; $display("FAIL sweep_y_structural abc=%03b got=%b exp=%b", v[2:0], y_str, tt[v]); end
         if (y_oth !== tt[v]) begin failures++; $display("FAIL sweep_y_other abc=%03b got=%b exp=%b", v[2:0], y_oth, tt[v]); end
         if (out_valid !== 1'b1) begin failures++; $display("FAIL sweep_out_valid abc=%03b got=%b exp=1", v[2:0], out_valid); end
         if (mismatch !== 1'b0) begin failures++; $display("FAIL sweep_mismatch abc=%03b got=%b exp=0", v[2:0], mismatch); end
      end
      checks += 2;
      if (vec_count !== 8'd8) begin failures++; $display("FAIL sweep_vec_count got=%0d exp=8", vec_count); end
      if (err_sticky !== 1'b0) begin failures++; $display("FAIL sweep_err_sticky got=%b exp=0", err_sticky); end
   endtask

   task automatic test_hold();
      drive(1'b0, 3'b000);
      for (int i = 0; i < 5; i++) begin
         step();
         checks += 4;
         if (y_str !== 2'b11 || y_oth !== 2'b11) begin failures++; $display("FAIL hold_y cyc=%0d got=%b/%b exp=11/11", i, y_str, y_oth); end
         if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=0", i, out_valid); end
         if (vec_count !== 8'd8) begin failures++; $display("FAIL hold_vec_count cyc=%0d got=%0d exp=8", i, vec_count); end
         if (mismatch !== 1'b0) begin failures++; $display("FAIL hold_mismatch cyc=%0d got=%b exp=0", i, mismatch); end
      end
   endtask

   task automatic test_bubble();
      logic       vin  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [2:0] vabc [4] = '{3'b011, 3'b111, 3'b100, 3'b111};
      logic [1:0] ey   [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
      for (int i = 0; i < 4; i++) begin
         drive(vin[i], vabc[i]);
         step();
         checks += 3;
         if (out_valid !== vin[i]) begin failures++; $display("FAIL bubble_out_valid step=%0d got=%b exp=%b", i, out_valid, vin[i]); end
         if (y_str !== ey[i]) begin failures++; $display("FAIL bubble_y_structural step=%0d got=%b exp=%b", i, y_str, ey[i]); end
         if (y_oth !== ey[i]) begin failures++; $display("FAIL bubble_y_other step=%0d got=%b exp=%b", i, y_oth, ey[i]); end
      end
      checks++;
      if (vec_count !== 8'd10) begin failures++; $display("FAIL bubble_vec_count got=%0d exp=10", vec_count); end
   endtask

   task automatic test_midreset();
      drive(1'b1, 3'b110);
      step();
      checks++;
      if (y_str !== 2'b10 || out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre got=%b/%b exp=10/1", y_str, out_valid); end
      drive(1'b1, 3'b111);
      #2;
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      if (y_str !== 2'b00 || y_oth !== 2'b00) begin failures++; $display("FAIL midrst_y got=%b/%b exp=00/00", y_str, y_oth); end
      if (mismatch !== 1'b0) begin failures++; $display("FAIL midrst_mismatch got=%b exp=0", mismatch); end
      if (err_sticky !== 1'b0) begin failures++; $display("FAIL midrst_err_sticky got=%b exp=0", err_sticky); end
      if (vec_count !== 8'd0) begin failures++; $display("FAIL midrst_vec_count got=%0d exp=0", vec_count); end
      step();
      rst_n = 1'b1;
      drive(1'b1, 3'b001);
      step();
      checks += 3;
      if (y_str !== 2'b01 || y_oth !== 2'b01) begin failures++; $display("FAIL midrst_first_y got=%b/%b exp=01/01", y_str, y_oth); end
      if (vec_count !== 8'd1) begin failures++; $display("FAIL midrst_first_vec_count got=%0d exp=1", vec_count); end
      if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_first_out_valid got=%b exp=1", out_valid); end
   endtask

   task automatic test_wrap();
      logic [1:0] ecnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 3'(i));
         step();
         checks++;
         if (vec_count2 !== ecnt[i]) begin failures++; $display("FAIL wrap_vec_count n=%0d got=%0d exp=%0d", i + 1, vec_count2, ecnt[i]); end
      end
      checks += 2;
      if (vec_count !== 8'd5) begin failures++; $display("FAIL wrap_wide_vec_count got=%0d exp=5", vec_count); end
      if (err_sticky2 !== 1'b0) begin failures++; $display("FAIL wrap_err_sticky got=%b exp=0", err_sticky2); end
   endtask

   task automatic test_fault();
      do_reset();
      force dut.carry_s = 1'b0;
      drive(1'b1, 3'b111);
      step();
      checks += 4;
      if (y_str !== 2'b01) begin failures++; $display("FAIL fault_y_structural got=%b exp=01", y_str); end
      if (y_oth !== 2'b11) begin failures++; $display("FAIL fault_y_other got=%b exp=11", y_oth); end
      if (mismatch !== 1'b1) begin failures++; $display("FAIL fault_mismatch got=%b exp=1", mismatch); end
      if (err_sticky !== 1'b1) begin failures++; $display("FAIL fault_err_sticky got=%b exp=1", err_sticky); end
      drive(1'b0, 3'b000);
      for (int i = 0; i < 3; i++) begin
         step();
         checks += 2;
         if (mismatch !== 1'b0) begin failures++; $display("FAIL fault_idle_mismatch cyc=%0d got=%b exp=0", i, mismatch); end
         if (err_sticky !== 1'b1) begin failures++; $display("FAIL fault_idle_err_sticky cyc=%0d got=%b exp=1", i, err_sticky); end
      end
      release dut.carry_s;
      drive(1'b1, 3'b011);
      step();
      checks += 3;
      if (y_str !== 2'b10) begin failures++; $display("FAIL fault_released_y got=%b exp=10", y_str); end
      if (mismatch !== 1'b0) begin failures++; $display("FAIL fault_released_mismatch got=%b exp=0", mismatch); end
      if (err_sticky !== 1'b1) begin failures++; $display("FAIL fault_released_err_sticky got=%b exp=1", err_sticky); end
      drive(1'b0, 3'b000);
      rst_n = 1'b0;
      #1;
      checks++;
      if (err_sticky !== 1'b0) begin failures++; $display("FAIL fault_reset_err_sticky got=%b exp=0", err_sticky); end
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_hold();
      test_bubble();
      test_midreset();
      test_wrap();
      test_fault();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
